// File: rtl/execute_stage_mc.sv
// rtl/execute_stage_mc.sv - Y86 execute stage with CC register, multi-cycle signed multiply and E->M register
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   E_icode/E_ifun/E_valA/E_valB/E_valC/E_dstE/E_dstM/E_stat   instruction in E
//   m_stat, W_stat                  downstream status codes that gate CC writes
//   M_stall, M_bubble               M register hold / nop-insert controls
//   e_busy                          multiply in progress, upstream stages must stall
//   e_valE, e_dstE, e_cnd           combinational execute results (forwarding)
//   cc                              {ZF,SF,OF}
//   M_*                             E->M pipeline register outputs
module execute_stage_mc #(
  parameter int         W        = 64,
  parameter bit         EN_MUL   = 1'b1,
  parameter logic [3:0] STAT_AOK = 4'b1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [3:0]   E_stat,
  input  logic [3:0]   m_stat,
  input  logic [3:0]   W_stat,
  input  logic         M_stall,
  input  logic         M_bubble,
  output logic         e_busy,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_cnd,
  output logic [2:0]   cc,
  output logic [3:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} mul_state_e;

  mul_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;     // {partial high, remaining multiplier bits}
  logic [W-1:0]     mcand_q, mcand_d;
  logic             neg_q, neg_d;
  logic [2:0]       cc_q, cc_d;

  logic [3:0]       m_stat_q, m_icode_q, m_dste_q, m_dstm_q;
  logic             m_cnd_q;
  logic [W-1:0]     m_vale_q, m_vala_q;

  logic             is_opq, is_mull, mul_done, busy;
  logic [W-1:0]     abs_a, abs_b;
  logic [W:0]       step_sum;
  logic [2*W-1:0]   prod_signed;
  logic [W-1:0]     prod_lo, prod_hi;
  logic             mul_of;

  logic [W-1:0]     val_e;
  logic             alu_of, op_valid, cnd, cc_upd;
  logic             zf, sf, of;

  assign is_opq  = (E_icode == 4'h6);
  assign is_mull = EN_MUL && is_opq && (E_ifun == 4'h4);

  // The magnitude of the most negative value still fits in W unsigned bits.
  assign abs_a = E_valA[W-1] ? (~E_valA + W'(1)) : E_valA;
  assign abs_b = E_valB[W-1] ? (~E_valB + W'(1)) : E_valB;

  // One multiplier bit per cycle: add the multiplicand into the high half when
  // the current LSB is set, then shift the whole accumulator right by one.
  assign step_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});

  assign prod_signed = neg_q ? (~acc_q + (2*W)'(1)) : acc_q;
  assign prod_lo     = prod_signed[W-1:0];
  assign prod_hi     = prod_signed[2*W-1:W];
  assign mul_of      = (prod_hi != {W{prod_lo[W-1]}});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    busy     = 1'b0;
    mul_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mull) begin
          busy    = 1'b1;
          mcand_d = abs_a;
          acc_d   = {{W{1'b0}}, abs_b};
          neg_d   = E_valA[W-1] ^ E_valB[W-1];
          cnt_d   = CW'(W-1);
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        busy  = 1'b1;
        acc_d = {step_sum, acc_q[W-1:1]};
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DONE: begin
        mul_done = 1'b1;
        if (!M_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    val_e    = '0;
    alu_of   = 1'b0;
    op_valid = 1'b0;
    case (E_icode)
      4'h2:        val_e = E_valA;
      4'h3:        val_e = E_valC;
      4'h4, 4'h5:  val_e = E_valB + E_valC;
      4'h8, 4'hA:  val_e = E_valB - W'(8);
      4'h9, 4'hB:  val_e = E_valB + W'(8);
      4'h6: begin
        case (E_ifun)
          4'h0: begin
            val_e    = E_valB + E_valA;
            alu_of   = (E_valA[W-1] == E_valB[W-1]) && (val_e[W-1] != E_valA[W-1]);
            op_valid = 1'b1;
          end
          4'h1: begin
            val_e    = E_valB - E_valA;
            alu_of   = (E_valA[W-1] != E_valB[W-1]) && (val_e[W-1] != E_valB[W-1]);
            op_valid = 1'b1;
          end
          4'h2: begin
            val_e    = E_valB & E_valA;
            op_valid = 1'b1;
          end
          4'h3: begin
            val_e    = E_valB ^ E_valA;
            op_valid = 1'b1;
          end
          4'h4: begin
            // Result only appears once the product is complete.
            if (EN_MUL && mul_done) begin
              val_e    = prod_lo;
              alu_of   = mul_of;
              op_valid = 1'b1;
            end
          end
          default: val_e = '0;
        endcase
      end
      default: val_e = '0;
    endcase
  end

  assign zf = cc_q[2];
  assign sf = cc_q[1];
  assign of = cc_q[0];

  always_comb begin
    cnd = 1'b0;
    if (E_icode == 4'h2 || E_icode == 4'h7) begin
      case (E_ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf ^ of) | zf;
        4'h2:    cnd = sf ^ of;
        4'h3:    cnd = zf;
        4'h4:    cnd = ~zf;
        4'h5:    cnd = ~(sf ^ of);
        4'h6:    cnd = ~(sf ^ of) & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  // A faulting instruction further down the pipe must not see its younger OPq change CC.
  assign cc_upd = is_opq && op_valid && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);
  assign cc_d   = cc_upd ? {(val_e == '0), val_e[W-1], alu_of} : cc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      cc_q    <= 3'b100;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      cc_q    <= cc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stat_q  <= STAT_AOK;
      m_icode_q <= 4'h1;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= 4'hF;
      m_dstm_q  <= 4'hF;
    end else if (M_stall) begin
      m_stat_q  <= m_stat_q;
    end else if (M_bubble || busy) begin
      m_stat_q  <= STAT_AOK;
      m_icode_q <= 4'h1;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= 4'hF;
      m_dstm_q  <= 4'hF;
    end else begin
      m_stat_q  <= E_stat;
      m_icode_q <= E_icode;
      m_cnd_q   <= cnd;
      m_vale_q  <= val_e;
      m_vala_q  <= E_valA;
      m_dste_q  <= e_dstE;
      m_dstm_q  <= E_dstM;
    end
  end

  assign e_busy  = busy;
  assign e_valE  = val_e;
  assign e_cnd   = cnd;
  assign e_dstE  = (E_icode == 4'h2 && !cnd) ? 4'hF : E_dstE;
  assign cc      = cc_q;
  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_cnd   = m_cnd_q;
  assign M_valE  = m_vale_q;
  assign M_valA  = m_vala_q;
  assign M_dstE  = m_dste_q;
  assign M_dstM  = m_dstm_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// tb/tb_execute_stage_mc.sv - directed self-checking bench for execute_stage_mc
module tb_execute_stage_mc;

  localparam int         W   = 64;
  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] ADR = 4'b0011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM, E_stat, m_stat, W_stat;
  logic [W-1:0] E_valA, E_valB, E_valC;
  logic         M_stall, M_bubble;
  logic         e_busy, e_cnd, M_cnd;
  logic [W-1:0] e_valE, M_valE, M_valA;
  logic [3:0]   e_dstE, M_stat, M_icode, M_dstE, M_dstM;
  logic [2:0]   cc;

  int vectors = 0;
  int miscompares = 0;
  int n;

  execute_stage_mc #(.W(W), .EN_MUL(1'b1), .STAT_AOK(AOK)) dut (
    .clk(clk), .rst_n(rst_n),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_stat(E_stat), .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble),
    .e_busy(e_busy), .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = de; E_dstM = dm;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
    E_stat = AOK; m_stat = AOK; W_stat = AOK;
    drive(4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
    step();
    chk("rst_cc", cc, 3'b100);
    chk("rst_M_icode", M_icode, 4'h1);
    chk("rst_M_stat", M_stat, AOK);
    chk("rst_M_cnd", M_cnd, 1'b0);
    chk("rst_M_valE", M_valE, 0);
    chk("rst_M_valA", M_valA, 0);
    chk("rst_M_dstE", M_dstE, 4'hF);
    chk("rst_M_dstM", M_dstM, 4'hF);
    chk("rst_busy", e_busy, 1'b0);
    rst_n = 1'b1;

    // add overflow: 7FFF..F + 1
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, '0, 4'h2, 4'hA);
    chk("add_e_valE", e_valE, 64'h8000_0000_0000_0000);
    step();
    chk("add_M_valE", M_valE, 64'h8000_0000_0000_0000);
    chk("add_M_valA", M_valA, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("add_M_icode", M_icode, 4'h6);
    chk("add_M_dstE", M_dstE, 4'h2);
    chk("add_M_dstM", M_dstM, 4'hA);
    chk("add_cc", cc, 3'b011);

    // conditions with ZF=0 SF=1 OF=1
    drive(4'h2, 4'h3, 64'h55, '0, '0, 4'h3, 4'hF);
    chk("cmove_cnd", e_cnd, 1'b0);
    chk("cmove_dstE", e_dstE, 4'hF);
    chk("cmove_valE", e_valE, 64'h55);
    step();
    chk("cmove_M_dstE", M_dstE, 4'hF);
    chk("cmove_M_cnd", M_cnd, 1'b0);
    chk("cmove_cc", cc, 3'b011);
    drive(4'h2, 4'h0, 64'h55, '0, '0, 4'h3, 4'hF);
    chk("rrmov_cnd", e_cnd, 1'b1);
    chk("rrmov_dstE", e_dstE, 4'h3);
    drive(4'h7, 4'h2, '0, '0, '0, 4'hF, 4'hF);
    chk("jl_cnd", e_cnd, 1'b0);
    drive(4'h7, 4'h1, '0, '0, '0, 4'hF, 4'hF);
    chk("jle_cnd", e_cnd, 1'b0);
    drive(4'h7, 4'h4, '0, '0, '0, 4'hF, 4'hF);
    chk("jne_cnd", e_cnd, 1'b1);
    drive(4'h7, 4'h6, '0, '0, '0, 4'hF, 4'hF);
    chk("jg_cnd", e_cnd, 1'b1);
    drive(4'h7, 4'h8, '0, '0, '0, 4'hF, 4'hF);
    chk("j8_cnd", e_cnd, 1'b0);
    drive(4'h3, 4'h4, '0, '0, '0, 4'hF, 4'hF);
    chk("other_icode_cnd", e_cnd, 1'b0);

    // CC gated by downstream exception
    m_stat = ADR;
    drive(4'h6, 4'h1, 64'h5, 64'h5, '0, 4'h4, 4'hF);
    chk("sub_gated_valE", e_valE, 0);
    step();
    chk("sub_gated_M_valE", M_valE, 0);
    chk("sub_gated_cc", cc, 3'b011);
    m_stat = AOK; W_stat = ADR;
    step();
    chk("sub_wgated_cc", cc, 3'b011);
    W_stat = AOK;
    step();
    chk("sub_cc", cc, 3'b100);

    drive(4'h6, 4'h3, 64'hFF, 64'hF0, '0, 4'h4, 4'hF);
    chk("xor_valE", e_valE, 64'h0F);
    step();
    chk("xor_cc", cc, 3'b000);
    drive(4'h6, 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, '0, 4'h4, 4'hF);
    step();
    chk("and_M_valE", M_valE, 64'h8000_0000_0000_0000);
    chk("and_cc", cc, 3'b010);
    drive(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, '0, 4'h4, 4'hF);
    chk("subof_valE", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    step();
    chk("subof_cc", cc, 3'b001);

    // address arithmetic
    drive(4'h3, 4'h0, 64'h9, 64'h9, 64'h123, 4'h1, 4'hF);
    chk("irmov_valE", e_valE, 64'h123);
    drive(4'h4, 4'h0, '0, 64'h100, 64'h20, 4'hF, 4'hF);
    chk("rmmov_valE", e_valE, 64'h120);
    drive(4'h8, 4'h0, '0, 64'h100, '0, 4'h4, 4'hF);
    chk("call_valE", e_valE, 64'hF8);
    drive(4'hB, 4'h0, '0, 64'h100, '0, 4'h4, 4'h5);
    chk("pop_valE", e_valE, 64'h108);

    // invalid OPq
    E_stat = ADR;
    drive(4'h6, 4'h5, 64'h3, 64'h4, '0, 4'h2, 4'hF);
    chk("inv_valE", e_valE, 0);
    step();
    chk("inv_M_valE", M_valE, 0);
    chk("inv_M_icode", M_icode, 4'h6);
    chk("inv_M_stat", M_stat, ADR);
    chk("inv_cc", cc, 3'b001);
    E_stat = AOK;

    // bubble, then stall winning over bubble
    M_bubble = 1'b1;
    drive(4'h6, 4'h0, 64'h1, 64'h1, '0, 4'h2, 4'hF);
    step();
    chk("bub_M_icode", M_icode, 4'h1);
    chk("bub_M_dstE", M_dstE, 4'hF);
    chk("bub_cc", cc, 3'b000);
    M_stall = 1'b1;
    drive(4'h6, 4'h0, 64'h3, 64'h4, '0, 4'h2, 4'hF);
    step();
    chk("stall_M_icode", M_icode, 4'h1);
    chk("stall_M_valE", M_valE, 0);
    M_stall = 1'b0; M_bubble = 1'b0;

    // mull 7 * -3
    drive(4'h6, 4'h4, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, '0, 4'h5, 4'hF);
    chk("mul1_busy0", e_busy, 1'b1);
    chk("mul1_valE0", e_valE, 0);
    n = 0;
    while (e_busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk("mul1_busy_cycles", n, 65);
    chk("mul1_M_nop", M_icode, 4'h1);
    chk("mul1_done_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFEB);
    step();
    chk("mul1_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul1_M_icode", M_icode, 4'h6);
    chk("mul1_M_dstE", M_dstE, 4'h5);
    chk("mul1_cc", cc, 3'b010);
    drive(4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);

    // mull 2^40 * 2^40 with a 3-cycle M stall in DONE
    drive(4'h6, 4'h4, 64'h0000_0100_0000_0000, 64'h0000_0100_0000_0000, '0, 4'h7, 4'hF);
    n = 0;
    while (e_busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
    chk("mul2_busy_cycles", n, 65);
    M_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mul2_stall_busy", e_busy, 1'b0);
      chk("mul2_stall_valE", e_valE, 0);
      chk("mul2_stall_M_icode", M_icode, 4'h1);
      chk("mul2_stall_cc", cc, 3'b101);
    end
    M_stall = 1'b0;
    step();
    chk("mul2_M_icode", M_icode, 4'h6);
    chk("mul2_M_dstE", M_dstE, 4'h7);
    chk("mul2_M_valE", M_valE, 0);
    chk("mul2_cc", cc, 3'b101);
    drive(4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);

    // reset in the middle of a multiply, then restart
    drive(4'h6, 4'h4, 64'hFFFF_FFFF_FFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFF5, '0, 4'h6, 4'hF);
    repeat (11) step();
    chk("mul3_busy_mid", e_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mul3_rst_cc", cc, 3'b100);
    chk("mul3_rst_M_icode", M_icode, 4'h1);
    chk("mul3_rst_M_valE", M_valE, 0);
    chk("mul3_rst_M_dstE", M_dstE, 4'hF);
    chk("mul3_rst_M_stat", M_stat, AOK);
    step();
    rst_n = 1'b1;
    n = 0;
    while (M_icode !== 4'h6 && n < 200) begin
      n++;
      step();
    end
    chk("mul3_restart_cycles", n, 66);
    chk("mul3_M_valE", M_valE, 64'h63);
    chk("mul3_cc", cc, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
